// File: rtl/dual_issue_hazard_ctrl.sv
// Per-register scoreboard and in-order dual-issue controller between the decoder and the RF stage.
// Holds a pair on RAW/WAW hazards against in-flight results, or splits it so that odd issues later.
module dual_issue_hazard_ctrl (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid_even,
    input  logic       i_valid_odd,
    input  logic [6:0] i_reg_dst_even,
    input  logic [6:0] i_reg_dst_odd,
    input  logic       i_reg_wr_even,
    input  logic       i_reg_wr_odd,
    input  logic [3:0] i_latency_even,
    input  logic [3:0] i_latency_odd,
    input  logic [6:0] i_ra_addr_even,
    input  logic [6:0] i_rb_addr_even,
    input  logic [6:0] i_rc_addr_even,
    input  logic [6:0] i_ra_addr_odd,
    input  logic [6:0] i_rb_addr_odd,
    input  logic [6:0] i_rc_addr_odd,
    input  logic       i_ra_use_even,
    input  logic       i_rb_use_even,
    input  logic       i_rc_use_even,
    input  logic       i_ra_use_odd,
    input  logic       i_rb_use_odd,
    input  logic       i_rc_use_odd,
    input  logic       i_flush,
    output logic       o_issue_even,
    output logic       o_issue_odd,
    output logic       o_id_advance,
    output logic       o_split,
    output logic       o_lat_err
);

    // state    | meaning
    // PAIR     | evaluating the even/odd pair presented by the decoder
    // ODD_LEFT | even already issued, holding the odd instruction until it is ready
    localparam logic S_PAIR     = 1'b0;
    localparam logic S_ODD_LEFT = 1'b1;

    logic       r_state;
    logic       r_lat_err;
    logic [2:0] r_cnt [128];

    logic       w_next_state;
    logic       w_issue_even;
    logic       w_issue_odd;
    logic       w_id_advance;
    logic [2:0] w_leff_even;
    logic [2:0] w_leff_odd;
    logic       w_bad_lat_even;
    logic       w_bad_lat_odd;
    logic       w_src_ok_even;
    logic       w_src_ok_odd;
    logic       w_waw_ok_even;
    logic       w_waw_ok_odd;
    logic       w_rdy_even;
    logic       w_rdy_odd;
    logic       w_conflict;

    // Latency 0 or above 7 cannot be tracked in 3 bits; treat as the slowest stage.
    assign w_bad_lat_even = (i_latency_even == 4'd0) || (i_latency_even > 4'd7);
    assign w_bad_lat_odd  = (i_latency_odd == 4'd0)  || (i_latency_odd > 4'd7);
    assign w_leff_even    = w_bad_lat_even ? 3'd7 : i_latency_even[2:0];
    assign w_leff_odd     = w_bad_lat_odd  ? 3'd7 : i_latency_odd[2:0];

    assign w_src_ok_even = (!i_ra_use_even || (r_cnt[i_ra_addr_even] == 3'd0))
                        && (!i_rb_use_even || (r_cnt[i_rb_addr_even] == 3'd0))
                        && (!i_rc_use_even || (r_cnt[i_rc_addr_even] == 3'd0));
    assign w_src_ok_odd  = (!i_ra_use_odd || (r_cnt[i_ra_addr_odd] == 3'd0))
                        && (!i_rb_use_odd || (r_cnt[i_rb_addr_odd] == 3'd0))
                        && (!i_rc_use_odd || (r_cnt[i_rc_addr_odd] == 3'd0));

    // A new writer must not land before an older in-flight write to the same register.
    assign w_waw_ok_even = !i_reg_wr_even || (r_cnt[i_reg_dst_even] < w_leff_even);
    assign w_waw_ok_odd  = !i_reg_wr_odd  || (r_cnt[i_reg_dst_odd]  < w_leff_odd);

    assign w_rdy_even = w_src_ok_even && w_waw_ok_even;
    assign w_rdy_odd  = w_src_ok_odd  && w_waw_ok_odd;

    assign w_conflict = i_reg_wr_even
                     && ((i_ra_use_odd && (i_ra_addr_odd == i_reg_dst_even))
                      || (i_rb_use_odd && (i_rb_addr_odd == i_reg_dst_even))
                      || (i_rc_use_odd && (i_rc_addr_odd == i_reg_dst_even))
                      || (i_reg_wr_odd && (i_reg_dst_odd == i_reg_dst_even)));

    always_comb begin
        w_issue_even = 1'b0;
        w_issue_odd  = 1'b0;
        w_id_advance = 1'b0;
        w_next_state = r_state;
        if (i_rst) begin
            w_next_state = S_PAIR;
        end else if (i_flush) begin
            w_id_advance = 1'b1;
            w_next_state = S_PAIR;
        end else if (r_state == S_ODD_LEFT) begin
            if (!i_valid_odd || w_rdy_odd) begin
                w_issue_odd  = i_valid_odd;
                w_id_advance = 1'b1;
                w_next_state = S_PAIR;
            end
        end else if (!i_valid_even) begin
            if (!i_valid_odd) begin
                w_id_advance = 1'b1;
            end else if (w_rdy_odd) begin
                w_issue_odd  = 1'b1;
                w_id_advance = 1'b1;
            end
        end else if (w_rdy_even) begin
            w_issue_even = 1'b1;
            if (!i_valid_odd) begin
                w_id_advance = 1'b1;
            end else if (w_rdy_odd && !w_conflict) begin
                w_issue_odd  = 1'b1;
                w_id_advance = 1'b1;
            end else begin
                w_next_state = S_ODD_LEFT;
            end
        end
    end

    assign o_issue_even = w_issue_even;
    assign o_issue_odd  = w_issue_odd;
    assign o_id_advance = w_id_advance;
    assign o_split      = !i_rst && (r_state == S_ODD_LEFT);
    assign o_lat_err    = r_lat_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_PAIR;
            r_lat_err <= 1'b0;
            for (int r = 0; r < 128; r++) begin
                r_cnt[r] <= 3'd0;
            end
        end else begin
            r_state   <= w_next_state;
            r_lat_err <= r_lat_err
                      || (w_issue_even && i_reg_wr_even && w_bad_lat_even)
                      || (w_issue_odd  && i_reg_wr_odd  && w_bad_lat_odd);
            // An issuing writer's load takes priority over the decrement of the same entry.
            for (int r = 0; r < 128; r++) begin
                if (w_issue_even && i_reg_wr_even && (i_reg_dst_even == 7'(r))) begin
                    r_cnt[r] <= w_leff_even - 3'd1;
                end else if (w_issue_odd && i_reg_wr_odd && (i_reg_dst_odd == 7'(r))) begin
                    r_cnt[r] <= w_leff_odd - 3'd1;
                end else if (r_cnt[r] != 3'd0) begin
                    r_cnt[r] <= r_cnt[r] - 3'd1;
                end
            end
        end
    end

endmodule
